// File: rtl/decode_issue_queue_pkg.sv
// decode_issue_queue_pkg
// Shared definitions for the decoded-instruction path between the decoder,
// the issue queue and the dispatcher. Both the decoder and the dispatcher
// pack and unpack a packet through the field offsets below, so the queue
// itself treats a packet as an opaque DECODE_DATA_WIDTH-bit word.
package decode_issue_queue_pkg;

  localparam int DECODE_DATA_WIDTH = 126;

  // Field offsets (LSB and MSB) inside one decoded packet.
  localparam int PC_LSB             = 0;
  localparam int PC_MSB             = 31;
  localparam int INST_LSB           = 32;
  localparam int INST_MSB           = 63;
  localparam int INST_VALID_BIT     = 64;
  localparam int ALUOP_LSB          = 65;
  localparam int ALUOP_MSB          = 72;
  localparam int ALUSEL_LSB         = 73;
  localparam int ALUSEL_MSB         = 75;
  localparam int IMM_LSB            = 76;
  localparam int IMM_MSB            = 107;
  localparam int REG1_READ_EN_BIT   = 108;
  localparam int REG2_READ_EN_BIT   = 109;
  localparam int REG1_READ_ADDR_LSB = 110;
  localparam int REG1_READ_ADDR_MSB = 114;
  localparam int REG2_READ_ADDR_LSB = 115;
  localparam int REG2_READ_ADDR_MSB = 119;
  localparam int REG_WRITE_EN_BIT   = 120;
  localparam int REG_WRITE_ADDR_LSB = 121;
  localparam int REG_WRITE_ADDR_MSB = 125;

  // The same layout as a packed struct (first member is the MSB end).
  typedef struct packed {
    logic [4:0]  reg_write_addr;
    logic        reg_write_en;
    logic [4:0]  reg2_read_addr;
    logic [4:0]  reg1_read_addr;
    logic        reg2_read_en;
    logic        reg1_read_en;
    logic [31:0] imm;
    logic [2:0]  alusel;
    logic [7:0]  aluop;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } decode_pkt_t;

  // Convenience accessor used by consumers that only need the PC.
  function automatic logic [31:0] pkt_pc(input logic [DECODE_DATA_WIDTH-1:0] pkt);
    return pkt[PC_MSB:PC_LSB];
  endfunction

endpackage

// File: rtl/decode_issue_queue_lane_compact.sv
// queue_lane_compact
// Purely combinational lane compactor. For each lane it produces the number
// of set lanes below it (the slot offset that lane is written to when sparse
// lanes are packed together) and the total number of set lanes.
// Ports:
//   lane_valid  in  N       per-lane flag
//   offset      out N*OW    lane i offset at [i*OW +: OW]
//   total       out OW      popcount of lane_valid
module queue_lane_compact #(
  parameter int N  = 2,
  parameter int OW = $clog2(N + 1)
) (
  input  logic [N-1:0]    lane_valid,
  output logic [N*OW-1:0] offset,
  output logic [OW-1:0]   total
);

  logic [OW-1:0] run;

  always_comb begin
    run    = '0;
    offset = '0;
    for (int i = 0; i < N; i++) begin
      offset[i*OW +: OW] = run;
      run = run + OW'(lane_valid[i]);
    end
    total = run;
  end

endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue
// Multi-lane circular instruction queue between decoder and dispatcher.
// Accepts up to ENQ_WIDTH packets per cycle (sparse lanes are compacted),
// presents the DEQ_WIDTH oldest entries first-word fall-through, and
// retires an in-order prefix of the accepted dequeue lanes.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   flush          synchronous discard of all contents
//   enq_valid      per-lane enqueue valid, any pattern
//   enq_data       lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   enq_ready      queue can take ENQ_WIDTH packets this cycle
//   pause_decoder  ~enq_ready, back-pressure toward fetch
//   deq_valid      thermometer code, lane i valid iff count > i
//   deq_data       oldest entries, lane 0 oldest
//   deq_accept     per-lane consume request
//   count, empty   occupancy
//
// Handshake: an enqueue lane transfers on an edge where enq_valid[i] and
// enq_ready are both high (and neither flush nor rst); data offered while
// enq_ready is low is dropped and must be held upstream. A dequeue lane j
// transfers when deq_accept[j] and deq_valid[j] are high and every lower
// lane also transfers; accepts above the first non-transferring lane are
// ignored. enq_ready and deq_valid depend only on registered state.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DECODE_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int ENQ_WIDTH  = 2,
  parameter int DEQ_WIDTH  = 2,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [ENQ_WIDTH-1:0]            enq_valid,
  input  logic [ENQ_WIDTH*DATA_WIDTH-1:0] enq_data,
  output logic                            enq_ready,
  output logic                            pause_decoder,
  output logic [DEQ_WIDTH-1:0]            deq_valid,
  output logic [DEQ_WIDTH*DATA_WIDTH-1:0] deq_data,
  input  logic [DEQ_WIDTH-1:0]            deq_accept,
  output logic [CNT_W-1:0]                count,
  output logic                            empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int EOW   = $clog2(ENQ_WIDTH + 1);
  localparam int DOW   = $clog2(DEQ_WIDTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic [ENQ_WIDTH*EOW-1:0] enq_off;
  logic [EOW-1:0]           enq_cnt;
  logic [DEQ_WIDTH-1:0]     deq_lead;
  logic [DEQ_WIDTH*DOW-1:0] deq_off_unused;
  logic [DOW-1:0]           deq_k;
  logic                     do_enq;
  logic [EOW-1:0]           enq_cnt_eff;
  logic                     clear;

  // Status outputs come from the registered count only.
  assign enq_ready     = (CNT_W'(DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH);
  assign pause_decoder = ~enq_ready;
  assign count         = count_q;
  assign empty         = (count_q == '0);

  genvar j;
  generate
    for (j = 0; j < DEQ_WIDTH; j++) begin : g_deq
      assign deq_valid[j] = count_q > CNT_W'(j);
      assign deq_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[head_q + PTR_W'(j)];
    end
  endgenerate

  // Leading-ones mask of the granted accepts; its popcount is the number of
  // entries retired this cycle, so a gap in deq_accept stops retirement.
  always_comb begin
    logic run;
    run      = 1'b1;
    deq_lead = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      run         = run & deq_accept[i] & deq_valid[i];
      deq_lead[i] = run;
    end
  end

  queue_lane_compact #(.N(ENQ_WIDTH), .OW(EOW)) u_enq_compact (
    .lane_valid (enq_valid),
    .offset     (enq_off),
    .total      (enq_cnt)
  );

  queue_lane_compact #(.N(DEQ_WIDTH), .OW(DOW)) u_deq_count (
    .lane_valid (deq_lead),
    .offset     (deq_off_unused),
    .total      (deq_k)
  );

  assign clear       = rst | flush;
  assign do_enq      = enq_ready & ~clear;
  assign enq_cnt_eff = do_enq ? enq_cnt : '0;

  // Storage has no reset; writes are blocked while clearing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      if (do_enq && enq_valid[i]) begin
        mem[tail_q + PTR_W'(enq_off[i*EOW +: EOW])] <= enq_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(deq_k);
      tail_q  <= tail_q + PTR_W'(enq_cnt_eff);
      count_q <= count_q + CNT_W'(enq_cnt_eff) - CNT_W'(deq_k);
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// tb_decode_issue_queue
// Directed bench for decode_issue_queue at DEPTH=8, ENQ=2, DEQ=2. A queue
// of expected packets models the FIFO; every step checks status outputs
// and the valid deq lanes against it.
module tb_decode_issue_queue;
  import decode_issue_queue_pkg::*;

  localparam int W     = DECODE_DATA_WIDTH;
  localparam int DEPTH = 8;
  localparam int ENQ   = 2;
  localparam int DEQ   = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [ENQ-1:0]   enq_valid;
  logic [ENQ*W-1:0] enq_data;
  logic             enq_ready;
  logic             pause_decoder;
  logic [DEQ-1:0]   deq_valid;
  logic [DEQ*W-1:0] deq_data;
  logic [DEQ-1:0]   deq_accept;
  logic [CNT_W-1:0] count;
  logic             empty;

  logic [W-1:0] exp_q[$];
  int n_cmp;
  int n_fail;

  decode_issue_queue #(
    .DATA_WIDTH (W),
    .DEPTH      (DEPTH),
    .ENQ_WIDTH  (ENQ),
    .DEQ_WIDTH  (DEQ)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .enq_valid     (enq_valid),
    .enq_data      (enq_data),
    .enq_ready     (enq_ready),
    .pause_decoder (pause_decoder),
    .deq_valid     (deq_valid),
    .deq_data      (deq_data),
    .deq_accept    (deq_accept),
    .count         (count),
    .empty         (empty)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rnd_pkt();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model queue.
  task automatic check_state(input string tag);
    int sz;
    logic [DEQ-1:0] exp_v;
    sz = exp_q.size();
    for (int j = 0; j < DEQ; j++) exp_v[j] = (sz > j);
    chk({tag, ".count"}, 128'(count), 128'(sz));
    chk({tag, ".empty"}, 128'(empty), 128'(sz == 0));
    chk({tag, ".enq_ready"}, 128'(enq_ready), 128'((DEPTH - sz) >= ENQ));
    chk({tag, ".pause"}, 128'(pause_decoder), 128'((DEPTH - sz) < ENQ));
    chk({tag, ".deq_valid"}, 128'(deq_valid), 128'(exp_v));
    for (int j = 0; j < DEQ; j++) begin
      if (j < sz) chk($sformatf("%s.lane%0d", tag, j), 128'(deq_data[j*W +: W]), 128'(exp_q[j]));
    end
  endtask

  // driver: apply one cycle of inputs, advance the model at the edge, check.
  task automatic step(input string tag, input logic [ENQ-1:0] ev, input logic [W-1:0] d0,
                      input logic [W-1:0] d1, input logic [DEQ-1:0] acc,
                      input logic fl, input logic r);
    int sz;
    int k;
    bit ready;
    enq_valid  = ev;
    enq_data   = {d1, d0};
    deq_accept = acc;
    flush      = fl;
    rst        = r;
    sz    = exp_q.size();
    ready = (DEPTH - sz) >= ENQ;
    @(posedge clk);
    if (r || fl) begin
      exp_q.delete();
    end else begin
      k = 0;
      for (int j = 0; j < DEQ; j++) begin
        if (acc[j] && sz > j && k == j) k++;
      end
      for (int j = 0; j < k; j++) void'(exp_q.pop_front());
      if (ready) begin
        if (ev[0]) exp_q.push_back(d0);
        if (ev[1]) exp_q.push_back(d1);
      end
    end
    #1;
    enq_valid  = '0;
    deq_accept = '0;
    flush      = 1'b0;
    rst        = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [W-1:0] pa, pb, pc, pd, pe, pf;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    flush = 1'b0;
    enq_valid = '0;
    enq_data = '0;
    deq_accept = '0;
    @(posedge clk);
    #1;
    step("reset", 2'b00, '0, '0, 2'b00, 1'b0, 1'b1);
    chk("reset.count0", 128'(count), 128'(0));
    chk("reset.empty1", 128'(empty), 128'(1));
    chk("reset.ready1", 128'(enq_ready), 128'(1));

    // Two-lane enqueue, visible the next cycle.
    pa = rnd_pkt(); pb = rnd_pkt();
    step("enq_ab", 2'b11, pa, pb, 2'b00, 1'b0, 1'b0);
    chk("ab.lane0", 128'(deq_data[0 +: W]), 128'(pa));
    chk("ab.lane1", 128'(deq_data[W +: W]), 128'(pb));
    chk("ab.count2", 128'(count), 128'(2));
    step("idle", 2'b00, '0, '0, 2'b00, 1'b0, 1'b0);
    step("drain_ab", 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);

    // Sparse lane 1 only compacts into the head slot.
    pc = rnd_pkt();
    step("enq_c", 2'b10, rnd_pkt(), pc, 2'b00, 1'b0, 1'b0);
    chk("c.lane0", 128'(deq_data[0 +: W]), 128'(pc));
    chk("c.valid01", 128'(deq_valid), 128'(2'b01));
    step("drain_c", 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);

    // Fill to DEPTH-1: not ready even when the dispatcher drains.
    for (int i = 0; i < 3; i++) step("fill", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("fill7", 2'b01, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    chk("full.ready0", 128'(enq_ready), 128'(0));
    chk("full.pause1", 128'(pause_decoder), 128'(1));
    step("full_enq", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    chk("full.count7", 128'(count), 128'(7));
    step("full_deq", 2'b11, rnd_pkt(), rnd_pkt(), 2'b11, 1'b0, 1'b0);
    chk("full.count5", 128'(count), 128'(5));
    chk("full.ready1", 128'(enq_ready), 128'(1));
    for (int i = 0; i < 3; i++) step("drain", 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);

    // Non-prefix accept retires nothing; prefix accept retires one.
    pd = rnd_pkt(); pe = rnd_pkt(); pf = rnd_pkt();
    step("enq_de", 2'b11, pd, pe, 2'b00, 1'b0, 1'b0);
    step("enq_f", 2'b01, pf, rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("acc10", 2'b00, '0, '0, 2'b10, 1'b0, 1'b0);
    chk("acc10.count3", 128'(count), 128'(3));
    step("acc01", 2'b00, '0, '0, 2'b01, 1'b0, 1'b0);
    chk("acc01.lane0", 128'(deq_data[0 +: W]), 128'(pe));

    // Empty boundary: accept on an empty queue does nothing.
    step("drain2", 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
    step("acc_empty", 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
    chk("empty.count0", 128'(count), 128'(0));

    // Wrap: put head at slot 7 with lane 1 reading slot 0.
    step("wflush", 2'b00, '0, '0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("wfill", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("wdrain", 2'b00, '0, '0, 2'b11, 1'b0, 1'b0);
    step("w67", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("w01", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("whead7", 2'b00, '0, '0, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("wround", 2'($urandom_range(0, 3)), rnd_pkt(), rnd_pkt(),
           2'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Flush and reset mid-burst at count=4.
    step("fflush", 2'b00, '0, '0, 2'b00, 1'b1, 1'b0);
    step("f4a", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("f4b", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("flush_all", 2'b11, rnd_pkt(), rnd_pkt(), 2'b11, 1'b1, 1'b0);
    chk("flush.count0", 128'(count), 128'(0));
    chk("flush.valid00", 128'(deq_valid), 128'(0));
    chk("flush.ready1", 128'(enq_ready), 128'(1));
    step("r4a", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("r4b", 2'b11, rnd_pkt(), rnd_pkt(), 2'b00, 1'b0, 1'b0);
    step("rst_all", 2'b11, rnd_pkt(), rnd_pkt(), 2'b11, 1'b0, 1'b1);
    chk("rst.count0", 128'(count), 128'(0));
    chk("rst.empty1", 128'(empty), 128'(1));
    chk("rst.ready1", 128'(enq_ready), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised multi-lane instruction queue between the decoder and the dispatcher. Each cycle it accepts up to ENQ_WIDTH decoded-instruction packets and presents up to DEQ_WIDTH oldest entries, first-word fall-through. It adds three behaviours over the fixed two-lane queue: compaction of sparse valid enqueue lanes, partial in-order dequeue, and occupancy reporting. Its stall output replaces the decoder's pause signal to fetch.

## Interface
- DATA_WIDTH, 126: bits per decoded packet; the package width constant.
- DEPTH, 16: number of entries; power of two, at least 2*ENQ_WIDTH.
- ENQ_WIDTH, 2: enqueue lanes, 1..4.
- DEQ_WIDTH, 2: dequeue lanes, 1..4.
- CNT_W, $clog2(DEPTH)+1: derived occupancy width.

Ports:
- clk  in  1  single clock; every register updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous discard of all contents.
- enq_valid  in  ENQ_WIDTH  per-lane packet valid; any pattern is legal.
- enq_data  in  ENQ_WIDTH*DATA_WIDTH  lane i at [i*DATA_WIDTH +: DATA_WIDTH].
- enq_ready  out  1  queue can take ENQ_WIDTH packets this cycle.
- pause_decoder  out  1  equals ~enq_ready.
- deq_valid  out  DEQ_WIDTH  thermometer code; lane i is valid iff count > i.
- deq_data  out  DEQ_WIDTH*DATA_WIDTH  the oldest entries; lane 0 is the oldest.
- deq_accept  in  DEQ_WIDTH  per-lane consume request from the dispatcher.
- count  out  CNT_W  current occupancy.
- empty  out  1  count == 0.

## Operation
- Storage: DEPTH x DATA_WIDTH array, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, and a count register. Storage is not reset.
- Enqueue:
  - Happens when enq_ready && !flush && !rst.
  - Valid lanes are compacted in ascending lane order into slots tail, tail+1, ...
  - tail advances by popcount(enq_valid).
  - Example: enq_valid=2'b10 writes lane 1 into slot tail; tail advances by 1.
- enq_ready: (DEPTH - count) >= ENQ_WIDTH, from the registered count only. There is no same-cycle dequeue bypass, so ready is conservative.
- Enqueue while !enq_ready: ignored and not written. The upstream stage holds its data because pause_decoder is high.
- Dequeue:
  - Accepted count k = number of leading ones of (deq_accept & deq_valid) starting at lane 0.
  - Bits set above the first zero are ignored. A non-prefix pattern is a protocol error, tolerated this way.
  - head advances by k.
- Count update: count_next = count + popcount(enq written) - k. Simultaneous enqueue and dequeue are both applied in the same edge.
- Flush: head, tail and count go to 0 on the next edge. Enqueue and dequeue in the same cycle are discarded. flush has priority over both.
- rst: identical effect to flush, and has priority over everything.

## Timing
- Reset values: count=0, empty=1, deq_valid=0, enq_ready=1, pause_decoder=0. deq_data is don't-care while its lane is invalid, and the bench masks it with deq_valid.
- Enqueue-to-dequeue latency: a packet written at edge N appears on deq_data/deq_valid after edge N, i.e. in cycle N+1. There is no same-cycle pass-through.
- deq_data, deq_valid, empty, count and enq_ready are combinational from registers only. There is no combinational path from any input to any output.
- Wrap-around: lane j of deq reads slot (head+j) mod DEPTH. Compacted writes wrap the same way.
- Full boundary: with count = DEPTH-ENQ_WIDTH+1, enq_ready=0 even if the dispatcher dequeues in that cycle.
- Empty boundary: deq_accept while deq_valid=0 has no effect, and count never underflows.
- Reset or flush mid-burst: state cleared in one edge. enq_ready=1 the following cycle.

## Structure
- Shared package: DECODE_DATA_WIDTH (126) and packet field offsets:
  - pc [31:0], inst [63:32], inst_valid [64], aluop [72:65], alusel [75:73], imm [107:76]
  - reg1_read_en [108], reg2_read_en [109], reg1_read_addr [114:110], reg2_read_addr [119:115]
  - reg_write_en [120], reg_write_addr [125:121]
- The decoder and dispatcher both unpack through these offsets.
- One sub-module is natural: queue_lane_compact. It is combinational and maps enq_valid to a per-lane write offset plus a popcount. The same helper is reused for the dequeue leading-ones count.

## Test plan
Configuration for all scenarios: DEPTH=8, ENQ=2, DEQ=2.
- Reset, then enq_valid=11 with A,B, then idle -> in the next cycle deq_valid=11, deq lane0=A, lane1=B, count=2.
- enq_valid=10 with C in lane 1 on an empty queue -> deq lane0=C, deq_valid=01, count=1.
- Fill to count=7 -> enq_ready=0 and pause_decoder=1. Enqueue in that cycle is ignored and count stays 7. After two dequeues (count=5), enq_ready=1.
- Queue holds D,E,F; deq_accept=10 -> nothing consumed, count stays 3. deq_accept=01 -> D consumed, lane0=E next.
- Eight enqueue and dequeue rounds pushing head/tail past slot 7 -> FIFO order preserved across the wrap; deq lane1 reads slot 0 when head=7.
- flush asserted together with enq_valid=11 and deq_accept=11 at count=4 -> next cycle count=0, empty=1, deq_valid=00, enq_ready=1. Same result with rst instead of flush.
